// File: rtl/seg_pkg.sv
// Shared constants for seven-segment readback: active-low abcdefg patterns,
// special codes and the scan-decoder state encoding.
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] CODE_ERR   = 4'hE;
    localparam logic [3:0] CODE_BLANK = 4'hF;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_CAPT = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    typedef struct packed {
        logic [3:0] code;
        logic       blank;
        logic       err;
    } dec_t;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational decode of one active-low abcdefg pattern into a BCD code
// plus blank/error flags.
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [6:0] seg_n,
    output logic [3:0] code,
    output logic       blank,
    output logic       err
);

    always_comb begin
        code  = CODE_ERR;
        blank = 1'b0;
        err   = 1'b0;
        case (seg_n)
            SEG_0:     code = 4'd0;
            SEG_1:     code = 4'd1;
            SEG_2:     code = 4'd2;
            SEG_3:     code = 4'd3;
            SEG_4:     code = 4'd4;
            SEG_5:     code = 4'd5;
            SEG_6:     code = 4'd6;
            SEG_7:     code = 4'd7;
            SEG_8:     code = 4'd8;
            SEG_9:     code = 4'd9;
            SEG_BLANK: begin
                code  = CODE_BLANK;
                blank = 1'b1;
            end
            default:   err = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Watches multiplexed active-low segment/anode lines, accepts each digit once
// it has been stable long enough, and publishes a frame when all positions are seen.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int NDIG       = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [6:0]        seg_n,
    input  logic [NDIG-1:0]   an_n,
    output logic [4*NDIG-1:0] digits_o,
    output logic [NDIG-1:0]   blank_o,
    output logic [NDIG-1:0]   err_o,
    output logic              frame_valid,
    output logic              frame_err
);

    localparam int W  = NDIG + 7;
    localparam int CW = (STABLE_CYC > 2) ? $clog2(STABLE_CYC) : 1;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYC - 1);

    logic [W-1:0]    sync1_reg, sync2_reg, prev_reg;
    logic [CW-1:0]   cnt_reg;
    logic [1:0]      state_reg, state_next;
    logic [NDIG-1:0] seen_reg;
    logic [IW-1:0]   cap_idx_reg, idx;
    dec_t            cap_reg, dec;
    dec_t            shadow_reg [NDIG];
    dec_t            out_reg    [NDIG];

    logic [NDIG-1:0] cur_an;
    logic            same, all_off, one_low, stable, frame_done, multi_evt, capture_go;

    assign cur_an     = sync2_reg[W-1:7];
    assign same       = (sync2_reg == prev_reg);
    assign all_off    = &cur_an;
    assign one_low    = $onehot(~cur_an);
    // Both the counter and the live comparison must agree, so a change on the
    // very cycle the count saturates cannot be captured.
    assign stable     = (cnt_reg == CNT_MAX) && same;
    assign frame_done = &seen_reg;
    assign capture_go = (state_reg == ST_WAIT) && !all_off && stable && one_low;
    assign multi_evt  = (state_reg == ST_WAIT) && !all_off && stable && !one_low;

    seg_pattern_decode u_decode (
        .seg_n (sync2_reg[6:0]),
        .code  (dec.code),
        .blank (dec.blank),
        .err   (dec.err)
    );

    always_comb begin
        idx = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (!cur_an[i]) idx = IW'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg <= '1;
            sync2_reg <= '1;
            prev_reg  <= '1;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= {an_n, seg_n};
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
            if (!same)
                cnt_reg <= '0;
            else if (cnt_reg != CNT_MAX)
                cnt_reg <= cnt_reg + 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (!all_off) state_next = ST_WAIT;
            ST_WAIT: begin
                if (all_off)
                    state_next = ST_IDLE;
                else if (stable)
                    state_next = one_low ? ST_CAPT : ST_HOLD;
            end
            ST_CAPT: state_next = ST_HOLD;
            ST_HOLD: if (!same) state_next = all_off ? ST_IDLE : ST_WAIT;
            default: state_next = ST_IDLE;
        endcase
    end

    // The stable sample is latched on entry to CAPT so a change arriving
    // during the capture cycle cannot corrupt the stored digit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            cap_idx_reg <= '0;
            cap_reg     <= '0;
            seen_reg    <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            frame_valid <= frame_done;
            if (capture_go) begin
                cap_idx_reg <= idx;
                cap_reg     <= dec;
            end
            if (frame_done)
                seen_reg <= '0;
            else if (state_reg == ST_CAPT)
                seen_reg[cap_idx_reg] <= 1'b1;
            if (multi_evt)
                frame_err <= 1'b1;
            else if (frame_done)
                frame_err <= 1'b0;
        end
    end

    generate
        for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    shadow_reg[gi] <= '0;
                    out_reg[gi]    <= '0;
                end else begin
                    if (state_reg == ST_CAPT && cap_idx_reg == IW'(gi))
                        shadow_reg[gi] <= cap_reg;
                    if (frame_done)
                        out_reg[gi] <= shadow_reg[gi];
                end
            end
            assign digits_o[4*gi +: 4] = out_reg[gi].code;
            assign blank_o[gi]         = out_reg[gi].blank;
            assign err_o[gi]           = out_reg[gi].err;
        end
    endgenerate

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed scan sequences; expected frames go into a queue that a separate
// monitor pops and compares whenever frame_valid pulses.
module tb_seg_scan_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  seg_n = 7'h7F;
    logic [3:0]  an_n = 4'hF;
    logic [15:0] digits_o;
    logic [3:0]  blank_o, err_o;
    logic        frame_valid, frame_err;

    int errors = 0;
    int checks = 0;
    int frames = 0;

    typedef struct {
        logic [15:0] d;
        logic [3:0]  b;
        logic [3:0]  e;
    } exp_t;
    exp_t exp_q[$];

    seg_scan_decoder #(.NDIG(4), .STABLE_CYC(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_n       (seg_n),
        .an_n        (an_n),
        .digits_o    (digits_o),
        .blank_o     (blank_o),
        .err_o       (err_o),
        .frame_valid (frame_valid),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Monitor: every frame_valid pulse consumes one expected frame.
    always @(negedge clk) begin
        if (!rst && frame_valid) begin
            frames++;
            $display("frame %0d: digits=%h blank=%b err=%b frame_err=%b",
                     frames, digits_o, blank_o, err_o, frame_err);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_frame: got digits=%h, required no frame", digits_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("frame_digits", 32'(digits_o), 32'(e.d));
                chk("frame_blank",  32'(blank_o),  32'(e.b));
                chk("frame_err_o",  32'(err_o),    32'(e.e));
            end
        end
    end

    task automatic show(input logic [3:0] an, input logic [6:0] seg, input int n);
        @(posedge clk);
        #1;
        an_n  = an;
        seg_n = seg;
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic idle(input int n);
        show(4'hF, 7'h7F, n);
    endtask

    task automatic push(input logic [15:0] d, input logic [3:0] b, input logic [3:0] e);
        exp_t x;
        x.d = d;
        x.b = b;
        x.e = e;
        exp_q.push_back(x);
    endtask

    task automatic wait_frames(input int target);
        int t = 0;
        while (frames < target && t < 100) begin
            @(posedge clk);
            t++;
        end
        @(negedge clk);
        chk("frame_count", 32'(frames), 32'(target));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_digits"},      32'(digits_o),    32'h0);
        chk({tag, "_blank"},       32'(blank_o),     32'h0);
        chk({tag, "_err"},         32'(err_o),       32'h0);
        chk({tag, "_frame_valid"}, 32'(frame_valid), 32'h0);
        chk({tag, "_frame_err"},   32'(frame_err),   32'h0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        idle(4);

        // Clean scan: 3,1,2,0
        push(16'h0213, 4'b0000, 4'b0000);
        show(4'b1110, 7'b0000110, 8);
        show(4'b1101, 7'b1001111, 8);
        show(4'b1011, 7'b0010010, 8);
        show(4'b0111, 7'b0000001, 8);
        idle(6);
        wait_frames(1);

        // Blank on digit 2, garbage on digit 1
        push(16'h0FE3, 4'b0100, 4'b0010);
        show(4'b1110, 7'b0000110, 8);
        show(4'b1101, 7'b1010101, 8);
        show(4'b1011, 7'b1111111, 8);
        show(4'b0111, 7'b0000001, 8);
        idle(6);
        wait_frames(2);

        // Too-short digit 0 must not count toward the frame
        show(4'b1110, 7'b0000000, 3);
        idle(4);
        show(4'b1101, 7'b1001100, 8);
        show(4'b1011, 7'b0100100, 8);
        show(4'b0111, 7'b0100000, 8);
        idle(20);
        chk("glitch_no_frame", 32'(frames), 32'd2);
        push(16'h6549, 4'b0000, 4'b0000);
        show(4'b1110, 7'b0000100, 8);
        idle(6);
        wait_frames(3);

        // Two anodes low at once
        show(4'b1100, 7'b0000000, 8);
        show(4'b1110, 7'b1001111, 8);
        chk("multi_frame_err_set", 32'(frame_err), 32'd1);
        show(4'b1101, 7'b0001111, 8);
        show(4'b1011, 7'b0000110, 8);
        chk("multi_frame_err_sticky", 32'(frame_err), 32'd1);
        push(16'h8371, 4'b0000, 4'b0000);
        show(4'b0111, 7'b0000000, 8);
        idle(6);
        wait_frames(4);
        @(negedge clk);
        chk("frame_err_cleared", 32'(frame_err), 32'd0);

        // Reset after two captures discards them
        show(4'b1110, 7'b0010010, 8);
        show(4'b1101, 7'b0010010, 8);
        idle(4);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_outputs("midreset");
        @(posedge clk);
        #1 rst = 1'b0;
        idle(4);
        push(16'h9765, 4'b0000, 4'b0000);
        show(4'b1110, 7'b0100100, 8);
        show(4'b1101, 7'b0100000, 8);
        show(4'b1011, 7'b0001111, 8);
        show(4'b0111, 7'b0000100, 8);
        idle(6);
        wait_frames(5);

        // Digit 0 recaptured: latest value wins
        push(16'h1007, 4'b0000, 4'b0000);
        show(4'b1110, 7'b0100100, 8);
        show(4'b1110, 7'b0001111, 8);
        show(4'b1101, 7'b0000001, 8);
        show(4'b1011, 7'b0000001, 8);
        show(4'b0111, 7'b1001111, 8);
        idle(6);
        wait_frames(6);

        idle(20);
        chk("final_frame_count", 32'(frames), 32'd6);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
